counter_monitor: RTL and testbench

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor.sv | 149 ++++++++++++++
 tb/tb_counter_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// counter_monitor: checks an external up-counter sample by sample.
// Optional wrap counting is built when COUNTER_MONITOR_WRAP_CNT_EN is defined.
module counter_monitor #(
    parameter int ERR_CNT_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clr_err,
    input  logic [CNT_W-1:0]     count_in,
    input  logic                 overflow_in,
    output logic                 locked,
    output logic [CNT_W-1:0]     expected,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [15:0]          wrap_count
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SYNC  = 2'b01;
    localparam logic [1:0] S_TRACK = 2'b10;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_locked;
    logic [CNT_W-1:0]     r_expected;
    logic                 r_err;
    logic [1:0]           r_err_code;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_all_ones;
    logic                 w_ovf_ok;
    logic                 w_sampling;
    logic                 w_in_track;
    logic                 w_val_err;
    logic                 w_ovf_err;
    logic                 w_any_err;
    logic                 w_err_sat;
    logic [CNT_W-1:0]     w_cnt_inc;

    // Per-sample checks; only a TRACK cycle with enable high can flag errors.
    always_comb begin
        w_all_ones = &count_in;
        w_ovf_ok   = (overflow_in == w_all_ones);
        w_sampling = enable &&
                     ((r_state == S_SYNC) || (r_state == S_TRACK));
        w_in_track = enable && (r_state == S_TRACK);
        w_val_err  = w_in_track && (count_in != r_expected);
        w_ovf_err  = w_in_track && !w_ovf_ok;
        w_any_err  = w_val_err || w_ovf_err;
        w_err_sat  = &r_err_count;
        w_cnt_inc  = count_in + CNT_W'(1);
    end

    // Next-state: dropping enable always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  w_state_nxt = S_SYNC;
                S_SYNC:  w_state_nxt = S_TRACK;
                S_TRACK: w_state_nxt = S_TRACK;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register; locked mirrors entry into TRACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt == S_TRACK);
        end
    end

    // Expected value resyncs on every observed sample in SYNC and TRACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected <= '0;
        end else if (w_sampling) begin
            r_expected <= w_cnt_inc;
        end
    end

    // Sticky error state; a clear wins over a same-cycle error.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_count <= '0;
        end else if (w_any_err) begin
            r_err      <= 1'b1;
            r_err_code <= {w_ovf_err, w_val_err};
            if (!w_err_sat) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

`ifdef COUNTER_MONITOR_WRAP_CNT_EN
    logic        r_prev_max;
    logic [15:0] r_wrap_count;
    logic        w_wrap_hit;

    // A wrap needs an all-ones sample with overflow set, then a clean zero.
    always_comb begin
        w_wrap_hit = w_in_track && r_prev_max &&
                     (count_in == '0) && !overflow_in;
    end

    // Remember whether the last sample was a correctly flagged all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_max <= 1'b0;
        end else if (w_sampling) begin
            r_prev_max <= w_all_ones && overflow_in;
        end else begin
            r_prev_max <= 1'b0;
        end
    end

    // Saturating count of correct wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_count <= '0;
        end else if (w_wrap_hit && (r_wrap_count != 16'hFFFF)) begin
            r_wrap_count <= r_wrap_count + 16'd1;
        end
    end

    assign wrap_count = r_wrap_count;
`else
    assign wrap_count = 16'h0000;
`endif

    assign locked    = r_locked;
    assign expected  = r_expected;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: directed vector table plus long-run,
// saturation and reset corner sequences for counter_monitor.
module tb_counter_monitor;

    typedef struct {
        logic        en;
        logic        clr;
        logic [15:0] cnt;
        logic        ovf;
        logic        locked;
        logic [15:0] expv;
        logic        err;
        logic [1:0]  code;
        logic [7:0]  ecnt;
        logic [15:0] wrap;
    } vec_t;

`ifdef COUNTER_MONITOR_WRAP_CNT_EN
    localparam logic [15:0] W1 = 16'd1;
`else
    localparam logic [15:0] W1 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clr_err;
    logic [15:0] count_in;
    logic        overflow_in;
    logic        locked;
    logic [15:0] expected;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic [15:0] wrap_count;

    int n_chk = 0;
    int n_err = 0;
    vec_t vt[21];

    always #5 clk = ~clk;

    counter_monitor #(.ERR_CNT_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clr_err    (clr_err),
        .count_in   (count_in),
        .overflow_in(overflow_in),
        .locked     (locked),
        .expected   (expected),
        .err        (err),
        .err_code   (err_code),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l,
                           input logic [15:0] e, input logic er,
                           input logic [1:0] c, input logic [7:0] ec,
                           input logic [15:0] w);
        chk({tag, ".locked"}, 32'(locked), 32'(l));
        chk({tag, ".expected"}, 32'(expected), 32'(e));
        chk({tag, ".err"}, 32'(err), 32'(er));
        chk({tag, ".err_code"}, 32'(err_code), 32'(c));
        chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(w));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0,
                   1'b0, 16'h0000, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[1]  = '{1'b1, 1'b0, 16'h000E, 1'b0,
                   1'b1, 16'h000F, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[2]  = '{1'b1, 1'b0, 16'h000F, 1'b0,
                   1'b1, 16'h0010, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[3]  = '{1'b1, 1'b0, 16'h0005, 1'b0,
                   1'b1, 16'h0006, 1'b1, 2'b01, 8'd1, 16'd0};
        vt[4]  = '{1'b1, 1'b0, 16'h0006, 1'b0,
                   1'b1, 16'h0007, 1'b1, 2'b01, 8'd1, 16'd0};
        vt[5]  = '{1'b1, 1'b0, 16'hFFFE, 1'b0,
                   1'b1, 16'hFFFF, 1'b1, 2'b01, 8'd2, 16'd0};
        vt[6]  = '{1'b1, 1'b0, 16'hFFFF, 1'b0,
                   1'b1, 16'h0000, 1'b1, 2'b10, 8'd3, 16'd0};
        vt[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0,
                   1'b1, 16'h0001, 1'b1, 2'b10, 8'd3, 16'd0};
        vt[8]  = '{1'b1, 1'b0, 16'h1234, 1'b1,
                   1'b1, 16'h1235, 1'b1, 2'b11, 8'd4, 16'd0};
        vt[9]  = '{1'b1, 1'b1, 16'h1235, 1'b0,
                   1'b1, 16'h1236, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[10] = '{1'b1, 1'b1, 16'h0000, 1'b0,
                   1'b1, 16'h0001, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[11] = '{1'b1, 1'b0, 16'h0001, 1'b0,
                   1'b1, 16'h0002, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[12] = '{1'b1, 1'b1, 16'hFFFE, 1'b0,
                   1'b1, 16'hFFFF, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[13] = '{1'b1, 1'b0, 16'hFFFF, 1'b1,
                   1'b1, 16'h0000, 1'b0, 2'b00, 8'd0, 16'd0};
        vt[14] = '{1'b1, 1'b0, 16'h0000, 1'b0,
                   1'b1, 16'h0001, 1'b0, 2'b00, 8'd0, W1};
        vt[15] = '{1'b1, 1'b0, 16'h0005, 1'b0,
                   1'b1, 16'h0006, 1'b1, 2'b01, 8'd1, W1};
        vt[16] = '{1'b0, 1'b0, 16'h1234, 1'b0,
                   1'b0, 16'h0006, 1'b1, 2'b01, 8'd1, W1};
        vt[17] = '{1'b0, 1'b0, 16'h1234, 1'b0,
                   1'b0, 16'h0006, 1'b1, 2'b01, 8'd1, W1};
        vt[18] = '{1'b1, 1'b0, 16'h8000, 1'b0,
                   1'b0, 16'h0006, 1'b1, 2'b01, 8'd1, W1};
        vt[19] = '{1'b1, 1'b0, 16'h8000, 1'b0,
                   1'b1, 16'h8001, 1'b1, 2'b01, 8'd1, W1};
        vt[20] = '{1'b1, 1'b0, 16'h8001, 1'b0,
                   1'b1, 16'h8002, 1'b1, 2'b01, 8'd1, W1};

        // Reset wins over enable and clr_err.
        rst         = 1'b1;
        enable      = 1'b1;
        clr_err     = 1'b1;
        count_in    = 16'h1234;
        overflow_in = 1'b1;
        step();
        chk_all("reset0", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0, 16'd0);
        step();
        chk_all("reset1", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0, 16'd0);

        // Long clean run through one full wrap.
        rst     = 1'b0;
        clr_err = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            count_in    = 16'(i);
            overflow_in = (16'(i) == 16'hFFFF);
            step();
        end
        chk_all("longrun", 1'b1, 16'h1170, 1'b0, 2'b00, 8'd0, W1);

        // Directed table from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            enable      = vt[i].en;
            clr_err     = vt[i].clr;
            count_in    = vt[i].cnt;
            overflow_in = vt[i].ovf;
            step();
            chk_all($sformatf("vec%0d", i), vt[i].locked, vt[i].expv,
                    vt[i].err, vt[i].code, vt[i].ecnt, vt[i].wrap);
        end

        // Saturation: err_count starts at 1, 300 bad cycles follow.
        enable      = 1'b1;
        clr_err     = 1'b0;
        count_in    = 16'h0000;
        overflow_in = 1'b0;
        for (int i = 0; i < 254; i++) step();
        chk("sat254.err_count", 32'(err_count), 32'hFF);
        for (int i = 0; i < 46; i++) step();
        chk_all("sat300", 1'b1, 16'h0001, 1'b1, 2'b01, 8'hFF, W1);

        // Reset mid-TRACK with an erroring sample records nothing.
        rst = 1'b1;
        step();
        chk_all("rst_track", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0, 16'd0);
        rst = 1'b0;
        step();
        chk_all("post_rst", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
